// File: rtl/m_tera_pkg.sv
// m_tera_pkg: shared state encoding and constants for the 8-bit fetch datapath.
package m_tera_pkg;
  localparam int W8 = 8;
  localparam logic [W8-1:0] HALT_OPCODE_DEF = 8'hFF;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_e;
endpackage

// File: rtl/m_2to1_8bit_mux_with_add1.sv
// m_2to1_8bit_mux_with_add1: out = in_1 + 1 when w_channel is high, else in_0.
module m_2to1_8bit_mux_with_add1
  import m_tera_pkg::*;
(
  input  logic          w_channel,
  input  logic [W8-1:0] in_1,
  input  logic [W8-1:0] in_0,
  output logic [W8-1:0] out
);
  assign out = w_channel ? in_1 + W8'(1) : in_0;
endmodule

// File: rtl/m_pc_fetch_sequencer.sv
// m_pc_fetch_sequencer: PC register, req/ack instruction fetch and a valid/ready instruction register.
// Define M_PC_FETCH_TIMEOUT_EN to halt with a sticky flag when memory stalls for TIMEOUT_CYCLES.
module m_pc_fetch_sequencer
  import m_tera_pkg::*;
#(
  parameter int            WIDTH       = W8,
  parameter logic [W8-1:0] RESET_PC    = 8'h00,
  parameter logic [W8-1:0] HALT_OPCODE = HALT_OPCODE_DEF
`ifdef M_PC_FETCH_TIMEOUT_EN
  ,
  parameter int            TIMEOUT_CYCLES = 16
`endif
) (
  input  logic             w_clock,
  input  logic             w_reset_n,
  input  logic             w_run,
  input  logic             w_branch_take,
  input  logic [WIDTH-1:0] w_bus_branch_target,
  output logic             w_mem_req,
  output logic [WIDTH-1:0] w_bus_mem_addr,
  input  logic             w_mem_ack,
  input  logic [WIDTH-1:0] w_bus_mem_data,
  output logic             w_ir_valid,
  input  logic             w_ir_ready,
  output logic [WIDTH-1:0] w_bus_ir,
  output logic [WIDTH-1:0] w_bus_pc,
  output logic             w_halted,
  output logic             w_fetch_timeout
);
  state_e           state_q;
  logic [WIDTH-1:0] pc_q, pc_d, ir_q;
  logic             mem_req_q, ir_valid_q, halted_q, consume;
  assign consume = (state_q == S_HOLD) && w_ir_ready;
  // Branch target only wins on the consume cycle; every other cycle the mux offers PC+1.
  m_2to1_8bit_mux_with_add1 u_next_pc (
    .w_channel(~(consume & w_branch_take)),
    .in_1     (pc_q),
    .in_0     (w_bus_branch_target),
    .out      (pc_d)
  );
`ifdef M_PC_FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_q;
  logic          timeout_q, limit;
  assign limit = wait_q == CW'(TIMEOUT_CYCLES - 1);
  assign w_fetch_timeout = timeout_q;
`else
  assign w_fetch_timeout = 1'b0;
`endif
  always_ff @(posedge w_clock or negedge w_reset_n)
    if (!w_reset_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      mem_req_q  <= 1'b0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
`ifdef M_PC_FETCH_TIMEOUT_EN
      wait_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else
      case (state_q)
        S_IDLE:
          if (w_run) begin
            state_q   <= S_REQ;
            mem_req_q <= 1'b1;
`ifdef M_PC_FETCH_TIMEOUT_EN
            wait_q    <= '0;
`endif
          end
        S_REQ:
          if (w_mem_ack) begin
            ir_q       <= w_bus_mem_data;
            ir_valid_q <= 1'b1;
            mem_req_q  <= 1'b0;
            state_q    <= S_HOLD;
          end
`ifdef M_PC_FETCH_TIMEOUT_EN
          else if (limit) begin
            mem_req_q <= 1'b0;
            timeout_q <= 1'b1;
            halted_q  <= 1'b1;
            state_q   <= S_HALT;
          end else
            wait_q <= wait_q + 1'b1;
`endif
        S_HOLD:
          if (w_ir_ready) begin
            pc_q       <= pc_d;
            ir_valid_q <= 1'b0;
            if (ir_q == HALT_OPCODE) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else if (w_run) begin
              state_q   <= S_REQ;
              mem_req_q <= 1'b1;
`ifdef M_PC_FETCH_TIMEOUT_EN
              wait_q    <= '0;
`endif
            end else
              state_q <= S_IDLE;
          end
        default: ;
      endcase
  assign w_mem_req      = mem_req_q;
  assign w_bus_mem_addr = pc_q;
  assign w_bus_pc       = pc_q;
  assign w_ir_valid     = ir_valid_q;
  assign w_bus_ir       = ir_q;
  assign w_halted       = halted_q;
endmodule

// File: tb/tb_m_pc_fetch_sequencer.sv
// tb_m_pc_fetch_sequencer: directed stimulus with an abstract fetch model checked every cycle,
// plus literal expectations for addresses, wrap, branch, halt, reset and timeout behaviour.
module tb_m_pc_fetch_sequencer;
  localparam logic [7:0] RPC = 8'h10;
`ifdef M_PC_FETCH_TIMEOUT_EN
  localparam int TMO = 4;
`endif
  logic       clk = 0, rst_n = 0, run = 0, br = 0, ready = 0, ack = 0;
  logic [7:0] tgt = 0, data = 0, addr, ir, pc;
  logic       req, valid, halted, tout;
  always #5 clk = ~clk;

  m_pc_fetch_sequencer #(.RESET_PC(RPC)
`ifdef M_PC_FETCH_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .w_clock(clk), .w_reset_n(rst_n), .w_run(run), .w_branch_take(br),
    .w_bus_branch_target(tgt), .w_mem_req(req), .w_bus_mem_addr(addr),
    .w_mem_ack(ack), .w_bus_mem_data(data), .w_ir_valid(valid),
    .w_ir_ready(ready), .w_bus_ir(ir), .w_bus_pc(pc), .w_halted(halted),
    .w_fetch_timeout(tout)
  );

  int total = 0, passed = 0;
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Abstract model: phase 0 idle, 1 waiting on memory, 2 instruction held, 3 stopped.
  int         ph = 0, waited = 0;
  logic [7:0] e_pc = RPC, e_ir = 8'h00;
  logic       e_to = 1'b0;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      ph = 0; e_pc = RPC; e_ir = 8'h00; e_to = 1'b0;
    end else if (ph == 0) begin
      if (run) begin ph = 1; waited = 0; end
    end else if (ph == 1) begin
      if (ack) begin e_ir = data; ph = 2; end
      else begin
        waited++;
`ifdef M_PC_FETCH_TIMEOUT_EN
        if (waited == TMO) begin ph = 3; e_to = 1'b1; end
`endif
      end
    end else if (ph == 2 && ready) begin
      e_pc = br ? tgt : e_pc + 8'd1;
      ph = (e_ir == 8'hFF) ? 3 : run ? 1 : 0;
      waited = 0;
    end
  end

  bit chk_en = 0;
  always @(negedge clk) if (chk_en) begin
    check("addr", addr, e_pc);
    check("pc", pc, e_pc);
    check("req", 8'(req), 8'(ph == 1));
    check("valid", 8'(valid), 8'(ph == 2));
    check("ir", ir, e_ir);
    check("halted", 8'(halted), 8'(ph == 3));
    check("timeout", 8'(tout), 8'(e_to));
  end

  // Memory responder: ack on the (ack_lat+1)-th cycle of a request; -1 never acks.
  logic [7:0] mem [256];
  logic [7:0] kick_data = 0;
  int         ack_lat = 1, age = 0;
  bit         kick = 0;
  initial forever begin
    @(negedge clk); #1;
    age = req ? age + 1 : 0;
    ack = kick || (req && ack_lat >= 0 && age == ack_lat + 1);
    data = kick ? kick_data : mem[addr];
  end

  logic [7:0] log_a[$];
  int         log_c[$];
  int         cyc = 0;
  logic       prev_req = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (req && !prev_req) begin log_a.push_back(addr); log_c.push_back(cyc); end
    prev_req <= req;
  end

  task automatic wait_for(input string name, input bit want_req);
    for (int i = 0; i < 60; i++) begin
      if (want_req ? req : valid) return;
      @(negedge clk);
    end
    total++;
    $display("FAIL %s: event never seen within 60 cycles", name);
  endtask
  task automatic consume(input bit b, input logic [7:0] t);
    wait_for("wait_valid", 0);
    ready = 1; br = b; tgt = t;
    @(negedge clk);
    ready = 0; br = 0;
  endtask
  task automatic pulse_reset();
    #2 rst_n = 0;
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
  endtask

  int n;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h01;
    mem[8'h30] = 8'hFF;
    mem[8'h41] = 8'h5A;
    @(posedge clk); @(negedge clk);
    chk_en = 1;
    check("rst_pc", pc, 8'h10);
    check("rst_req", 8'(req), 8'h00);
    check("rst_ir", ir, 8'h00);
    #2 rst_n = 1;
    @(negedge clk);
    // Back-to-back fetches with a one-cycle memory and a always-ready consumer.
    ready = 1; run = 1; ack_lat = 1;
    repeat (9) @(negedge clk);
    ready = 0;
    if (log_a.size() < 3) begin total++; $display("FAIL stream: got %0d fetches, expected 3", log_a.size()); end
    else begin
      check("stream_a0", log_a[0], 8'h10);
      check("stream_a1", log_a[1], 8'h11);
      check("stream_a2", log_a[2], 8'h12);
      check("stream_gap", 8'(log_c[2] - log_c[1]), 8'd3);
    end
    check("stream_ir", ir, 8'h01);
    // Branches on consume, then a branch pulse during REQ that must be ignored.
    consume(1, 8'h05); wait_for("req", 1); check("br_05", addr, 8'h05);
    consume(1, 8'h40); wait_for("req", 1); check("br_40", addr, 8'h40);
    br = 1; tgt = 8'h77; @(negedge clk); br = 0;
    consume(0, 8'h00); wait_for("req", 1); check("br_ignored", addr, 8'h41);
    wait_for("valid", 0); check("ir_5a", ir, 8'h5A);
    consume(1, 8'hFF); wait_for("req", 1); check("at_ff", addr, 8'hFF);
    consume(0, 8'h00); wait_for("req", 1); check("wrap", addr, 8'h00);
    // Stall the consumer for five cycles.
    wait_for("valid", 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 8'(valid), 8'h01);
      check("stall_ir", ir, 8'h01);
      check("stall_req", 8'(req), 8'h00);
    end
    // Halt opcode at 0x30.
    consume(1, 8'h30); wait_for("valid", 0); check("halt_op", ir, 8'hFF);
    consume(0, 8'h00);
    check("halted", 8'(halted), 8'h01);
    check("halt_pc", pc, 8'h31);
    ready = 1; n = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (req) n++; end
    ready = 0;
    check("halt_no_req", 8'(n), 8'h00);
    pulse_reset();
    check("post_halt_pc", pc, 8'h10);
    check("post_halt_halted", 8'(halted), 8'h00);
    // Reset during REQ: request drops at once and a late ack is ignored.
    ack_lat = -1;
    wait_for("req", 1);
    #2 rst_n = 0;
    #1 check("req_drop", 8'(req), 8'h00);
    @(negedge clk);
    run = 0;
    #2 rst_n = 1;
    @(negedge clk);
    kick = 1; kick_data = 8'h77;
    @(negedge clk);
    kick = 0;
    @(negedge clk);
    check("late_ack_valid", 8'(valid), 8'h00);
    check("late_ack_ir", ir, 8'h00);
    run = 1;
    wait_for("req", 1);
    n = 0;
`ifdef M_PC_FETCH_TIMEOUT_EN
    for (int i = 0; i < 20 && req; i++) begin n++; @(negedge clk); end
    check("to_cycles", 8'(n), 8'd4);
    check("to_flag", 8'(tout), 8'h01);
    check("to_halted", 8'(halted), 8'h01);
    pulse_reset();
    ack_lat = 3;
    wait_for("req", 1);
    wait_for("valid", 0);
    check("ack_at_limit_to", 8'(tout), 8'h00);
    check("ack_at_limit_ir", ir, 8'h01);
`else
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (req) n++; end
    check("wait_forever", 8'(n), 8'd20);
    check("no_timeout", 8'(tout), 8'h00);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
